// File: rtl/cfs_apb_slave_mem_if.sv
// rtl/cfs_apb_slave_mem_if.sv - APB bus signal bundle with master/slave views
interface cfs_apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/cfs_apb_slave_mem.sv
// rtl/cfs_apb_slave_mem.sv - APB slave word memory with programmable wait states
// and pslverr on out-of-range or misaligned accesses.
module cfs_apb_slave_mem #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int WAIT_WIDTH = 4
) (
    input  logic                          pclk,
    input  logic                          reset,
    cfs_apb_slave_mem_if.slave            apb,
    input  logic [WAIT_WIDTH-1:0]         wait_states
);
    localparam int BYTE_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [WAIT_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  setup;
    logic                  complete;
    logic                  waiting;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  setup_err;

    // Request decode happens only in the setup cycle; later bus changes are ignored.
    always_comb begin
        word_addr = apb.paddr >> BYTE_LSB;
        setup_err = (|(apb.paddr & ALIGN_MASK)) || (word_addr >= ADDR_WIDTH'(DEPTH));
        setup     = (state == IDLE) && apb.psel && !apb.penable;
        complete  = (state == ACCESS) && apb.psel && apb.penable && (cnt == '0);
        waiting   = (state == ACCESS) && apb.psel && apb.penable && (cnt != '0);
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!apb.psel || complete) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else if (setup) begin
            cnt     <= wait_states;
            idx_q   <= word_addr[IDX_W-1:0];
            write_q <= apb.pwrite;
            err_q   <= setup_err;
            wdata_q <= apb.pwdata;
        end else if (waiting) begin
            cnt <= cnt - 1'b1;
        end
    end

    // An aborted or reset-interrupted write never reaches this commit point.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (complete && write_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign apb.pready  = complete;
    assign apb.pslverr = complete && err_q;
    assign apb.prdata  = (complete && !write_q && !err_q) ? mem[idx_q] : '0;
endmodule

// File: tb/tb_cfs_apb_slave_mem.sv
// tb/tb_cfs_apb_slave_mem.sv - scoreboard bench for cfs_apb_slave_mem
module tb_cfs_apb_slave_mem;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int WW    = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    logic          pclk = 1'b0;
    logic          reset;
    logic [WW-1:0] wait_states;
    logic [31:0]   model [DEPTH];
    exp_t          sb [$];
    int            checks   = 0;
    int            failures = 0;

    always #5 pclk = ~pclk;

    cfs_apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    cfs_apb_slave_mem #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .WAIT_WIDTH(WW)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .apb        (apb),
        .wait_states(wait_states)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic addr_err(input logic [15:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    endfunction

    task automatic go_idle();
        @(posedge pclk); #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic setup_phase(input logic wr, input logic [15:0] addr, input logic [31:0] data, input int ws);
        @(posedge pclk); #1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = data;
        wait_states = ws[WW-1:0];
        @(negedge pclk);
        check_eq("setup_pready", {31'b0, apb.pready}, 32'd0);
        @(posedge pclk); #1;
        // Scramble bus after setup: the slave must use its latched request.
        apb.penable = 1'b1;
        apb.paddr   = addr ^ 16'h0004;
        apb.pwdata  = ~data;
        apb.pwrite  = ~wr;
        wait_states = '1;
    endtask

    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data, input int ws);
        exp_t e;
        int   n;
        bit   done;
        logic err;
        err      = addr_err(addr);
        e.err    = err;
        e.cycles = ws + 1;
        e.rdata  = (wr || err) ? 32'd0 : model[addr >> 2];
        sb.push_back(e);
        if (wr && !err) model[addr >> 2] = data;
        setup_phase(wr, addr, data, ws);
        done = 0;
        n    = 0;
        while (!done && n < 32) begin
            @(negedge pclk);
            n++;
            if (apb.pready) begin
                done = 1;
                e = sb.pop_front();
                check_eq("prdata", apb.prdata, e.rdata);
                check_eq("pslverr", {31'b0, apb.pslverr}, {31'b0, e.err});
                check_eq("access_cycles", n, e.cycles);
            end else begin
                check_eq("wait_prdata", apb.prdata | {31'b0, apb.pslverr}, 32'd0);
                @(posedge pclk); #1;
            end
        end
        if (!done) begin
            void'(sb.pop_front());
            check_eq("pready_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic xfer_abort(input logic [15:0] addr, input logic [31:0] data, input int ws);
        setup_phase(1'b1, addr, data, ws);
        @(negedge pclk);
        check_eq("abort_wait_pready", {31'b0, apb.pready}, 32'd0);
        @(posedge pclk); #1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check_eq("abort_pready", {31'b0, apb.pready}, 32'd0);
        end
    endtask

    task automatic xfer_reset(input logic [15:0] addr, input logic [31:0] data, input int ws);
        setup_phase(1'b1, addr, data, ws);
        @(negedge pclk);
        @(posedge pclk); #1;
        reset = 1'b1;
        @(negedge pclk);
        check_eq("rst_pready", {31'b0, apb.pready}, 32'd0);
        check_eq("rst_prdata", apb.prdata, 32'd0);
        check_eq("rst_pslverr", {31'b0, apb.pslverr}, 32'd0);
        @(posedge pclk); #1;
        reset       = 1'b0;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    endtask

    initial begin
        logic [15:0] a;
        reset       = 1'b1;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        wait_states = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        repeat (2) @(negedge pclk);
        check_eq("reset_pready", {31'b0, apb.pready}, 32'd0);
        check_eq("reset_prdata", apb.prdata, 32'd0);
        check_eq("reset_pslverr", {31'b0, apb.pslverr}, 32'd0);
        @(posedge pclk); #1;
        reset = 1'b0;

        xfer(1'b1, 16'h0004, 32'hDEADBEEF, 0);
        xfer(1'b0, 16'h0004, 32'h0, 0);
        go_idle();
        xfer(1'b0, 16'h0000, 32'h0, 3);
        go_idle();

        xfer(1'b1, 16'h0040, 32'hBAD0BAD0, 0);
        xfer(1'b1, 16'h0002, 32'hBAD1BAD1, 0);
        xfer(1'b0, 16'h0000, 32'h0, 0);
        xfer(1'b0, 16'h003C, 32'h0, 0);
        xfer(1'b0, 16'h0041, 32'h0, 1);

        xfer(1'b1, 16'h0008, 32'h00000011, 0);
        xfer(1'b1, 16'h000C, 32'h00000022, 0);
        xfer(1'b0, 16'h0008, 32'h0, 0);
        xfer(1'b0, 16'h000C, 32'h0, 0);
        go_idle();

        // Access phase without a setup cycle must be ignored.
        @(posedge pclk); #1;
        apb.psel    = 1'b1;
        apb.penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check_eq("no_setup_pready", {31'b0, apb.pready}, 32'd0);
        end
        go_idle();

        xfer_abort(16'h0010, 32'hA5A5A5A5, 2);
        xfer(1'b0, 16'h0010, 32'h0, 0);
        go_idle();

        xfer(1'b1, 16'h0014, 32'h00000055, 1);
        xfer(1'b0, 16'h0014, 32'h0, 0);
        xfer_reset(16'h0014, 32'h00000077, 3);
        xfer(1'b0, 16'h0014, 32'h0, 0);
        xfer(1'b0, 16'h0004, 32'h0, 0);

        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, DEPTH - 1) << 2);
            xfer(1'b1, a, $urandom, $urandom_range(0, 2));
            xfer(1'b0, a, 32'h0, $urandom_range(0, 2));
        end
        go_idle();

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cfs_apb_slave_mem.md
Name: cfs_apb_slave_mem

Overview:
- APB slave endpoint that consumes the APB bus signal set (paddr, pwrite, psel, penable, pwdata, pready, prdata, pslverr) and implements a word-addressed register memory.
- Inserts a run-time programmable number of wait states per transfer and flags out-of-range or misaligned accesses with pslverr.
- Sits directly downstream of the APB interface and serves as the DUT-side responder and the bench reference slave for the APB agent.

Parameters:
- ADDR_WIDTH, 16, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; legal values 8, 16, 32.
- DEPTH, 16, number of DATA_WIDTH words implemented; valid byte addresses 0 .. DEPTH*(DATA_WIDTH/8)-1.
- WAIT_WIDTH, 4, width of the wait_states input.

Ports:
- pclk  input  1  APB clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- paddr  input  ADDR_WIDTH  byte address.
- pwrite  input  1  1=write, 0=read.
- psel  input  1  slave select.
- penable  input  1  access phase indicator.
- pwdata  input  DATA_WIDTH  write data.
- pready  output  1  transfer complete.
- prdata  output  DATA_WIDTH  read data, valid only when pready=1.
- pslverr  output  1  error response, valid only when pready=1.
- wait_states  input  WAIT_WIDTH  wait cycles inserted per transfer; sampled in the setup cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE; wait counter = 0; all memory words = 0.
  - pready=0, prdata=0, pslverr=0.
- State machine states: IDLE, ACCESS.
  - IDLE -> ACCESS when psel=1 and penable=0 (setup cycle).
    - Latch paddr, pwrite, pwdata and wait_states into cnt.
    - Compute err = (paddr[log2(DATA_WIDTH/8)-1:0] != 0) or (word index >= DEPTH).
  - In IDLE, psel=1 with penable=1 (no setup seen) is ignored: pready stays 0 and no access occurs.
  - ACCESS, psel=1, penable=1, cnt!=0: cnt decrements by 1; pready=0.
  - ACCESS, psel=1, penable=1, cnt==0 (completion cycle):
    - pready=1.
    - Write with err=0: mem[index] <= latched pwdata at the end of this cycle.
    - Read with err=0: prdata = mem[index].
    - err=1: pslverr=1, no memory update, prdata=0.
    - Next state is IDLE.
  - ACCESS, psel=0: abort. Return to IDLE, no write, pready stays 0.
- Latency:
  - Total transfer length = 2 + wait_states cycles (setup + access + waits).
  - wait_states=0 gives pready in the first access cycle.
- Timing and bus rules:
  - pready, prdata and pslverr are combinational from state, cnt and latched request.
  - prdata and pslverr are 0 whenever pready=0.
  - Address, control and pwdata changes after the setup cycle are ignored; the latched values are used.
- Back-to-back: a new setup (psel=1, penable=0) in the cycle after completion starts a new transfer with no idle gap.
- Read-after-write to the same address returns the new data.
- Reset asserted mid-transfer: abort immediately, pending write is not committed, memory is cleared.
- wait_states changing during ACCESS has no effect on the current transfer.

Test Plan:
- Write 0xDEADBEEF to 0x0004 with wait_states=0, then read 0x0004 -> each transfer takes 2 cycles with pready high in cycle 2; read prdata=0xDEADBEEF, pslverr=0.
- wait_states=3, read 0x0000 after reset -> pready low for 3 access cycles, high on the 4th; prdata=0x00000000.
- Write to 0x0040 (index 16 = DEPTH) and to misaligned 0x0002 -> pslverr=1 with pready=1; subsequent reads of 0x0000 and 0x003C return unchanged data.
- Back-to-back write 0x0008=0x11, write 0x000C=0x22, read 0x0008, read 0x000C with no idle gap -> reads return 0x11 and 0x22; each transfer is 2 cycles.
- psel dropped during a wait state of a write of 0xA5A5A5A5 to 0x0010 with wait_states=2 -> pready never asserts; later read of 0x0010 returns 0.
- Write 0x55 to 0x0014, then assert reset for 1 cycle during a wait state of a write of 0x77 to 0x0014 -> all outputs 0 while reset is high; read of 0x0014 after release returns 0.
